// File: rtl/bus_master_port.sv
// bus_master_port
// Master-side port of the serial system bus. Takes one parallel read/write
// request from local master logic, requests the bus, shifts the 2-bit slave
// select to the arbiter and waits for grant. It then serialises command,
// address and write data, or collects read data from the slave. A withdrawn
// grant (split transaction) freezes the transfer at the current bit.
// Every output is a flop. Output values are decoded from the next state, so
// each output changes on the same edge as the state it belongs to.
module bus_master_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              MASTER_CLK,
   input  logic              MASTER_RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_slave,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              M_RQST,
   output logic              M_SLAVE_SEL,
   input  logic              M_GRANT,
   input  logic              ARB_BUSY,
   input  logic              BUS_BUSY,
   output logic              M_DOUT,
   output logic              M_DVALID,
   input  logic              S_DIN,
   input  logic              S_DVALID,
   output logic              M_TX_DONE
);

   // The transmit shift register is wide enough for the address or the data word.
   localparam int SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(SR_W + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ARM,
      ST_SEL0,
      ST_SEL1,
      ST_WAIT_GRANT,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } state_t;

   // Control and datapath state.
   state_t            r_state,   w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic              r_write,   w_write_nxt;
   logic [1:0]        r_slave,   w_slave_nxt;
   logic [SR_W-1:0]   r_tx_sr,   w_tx_sr_nxt;
   logic [DATA_W-1:0] r_wdata,   w_wdata_nxt;
   logic [DATA_W-1:0] r_rx_sr,   w_rx_sr_nxt;

   // Output flops.
   logic              r_req_ready,   w_req_ready_nxt;
   logic              r_rsp_valid,   w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
   logic              r_m_rqst,      w_m_rqst_nxt;
   logic              r_m_slave_sel, w_m_slave_sel_nxt;
   logic              r_m_dout,      w_m_dout_nxt;
   logic              r_m_dvalid,    w_m_dvalid_nxt;
   logic              r_m_tx_done,   w_m_tx_done_nxt;

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign M_RQST      = r_m_rqst;
   assign M_SLAVE_SEL = r_m_slave_sel;
   assign M_DOUT      = r_m_dout;
   assign M_DVALID    = r_m_dvalid;
   assign M_TX_DONE   = r_m_tx_done;

   // Next-state, datapath and registered-output decode for the transfer FSM.
   always_comb begin
      // NOTE: every variable gets its hold/idle value first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      w_state_nxt       = r_state;
      w_bit_cnt_nxt     = r_bit_cnt;
      w_write_nxt       = r_write;
      w_slave_nxt       = r_slave;
      w_tx_sr_nxt       = r_tx_sr;
      w_wdata_nxt       = r_wdata;
      w_rx_sr_nxt       = r_rx_sr;
      w_m_dout_nxt      = r_m_dout;
      w_m_dvalid_nxt    = 1'b0;
      w_req_ready_nxt   = 1'b0;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_rdata_nxt   = '0;
      w_m_rqst_nxt      = 1'b0;
      w_m_slave_sel_nxt = 1'b0;
      w_m_tx_done_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_req_ready && req_valid) begin
               w_write_nxt   = req_write;
               w_slave_nxt   = req_slave;
               w_tx_sr_nxt   = SR_W'(req_addr);
               w_wdata_nxt   = req_wdata;
               w_rx_sr_nxt   = '0;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_ARM;
            end
         end

         // Slave 0 has no bus target and completes without touching the bus.
         ST_ARM: begin
            if (r_slave == 2'd0) begin
               w_state_nxt = ST_DONE;
            end else if (!ARB_BUSY && !BUS_BUSY) begin
               w_state_nxt = ST_SEL0;
            end
         end

         ST_SEL0: w_state_nxt = ST_SEL1;

         ST_SEL1: w_state_nxt = ST_WAIT_GRANT;

         ST_WAIT_GRANT: begin
            if (M_GRANT) begin
               w_state_nxt    = ST_CMD;
               w_bit_cnt_nxt  = '0;
               w_m_dout_nxt   = r_write;
               w_m_dvalid_nxt = 1'b1;
            end
         end

         // In the transfer states, a sampled grant allows the next bit onto the
         // bus. Without grant, the counter and shift registers hold their values
         // and the bus sees M_DVALID low.
         ST_CMD: begin
            if (M_GRANT) begin
               w_state_nxt    = ST_ADDR;
               w_bit_cnt_nxt  = '0;
               w_m_dout_nxt   = r_tx_sr[0];
               w_tx_sr_nxt    = r_tx_sr >> 1;
               w_m_dvalid_nxt = 1'b1;
            end
         end

         ST_ADDR: begin
            if (M_GRANT) begin
               if (r_bit_cnt == ADDR_LAST) begin
                  w_bit_cnt_nxt = '0;
                  if (r_write) begin
                     w_state_nxt    = ST_WDATA;
                     w_m_dout_nxt   = r_wdata[0];
                     w_tx_sr_nxt    = SR_W'(r_wdata) >> 1;
                     w_m_dvalid_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_RDATA;
                  end
               end else begin
                  w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
                  w_m_dout_nxt   = r_tx_sr[0];
                  w_tx_sr_nxt    = r_tx_sr >> 1;
                  w_m_dvalid_nxt = 1'b1;
               end
            end
         end

         ST_WDATA: begin
            if (M_GRANT) begin
               if (r_bit_cnt == DATA_LAST) begin
                  w_state_nxt   = ST_DONE;
                  w_bit_cnt_nxt = '0;
               end else begin
                  w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
                  w_m_dout_nxt   = r_tx_sr[0];
                  w_tx_sr_nxt    = r_tx_sr >> 1;
                  w_m_dvalid_nxt = 1'b1;
               end
            end
         end

         // Read bits arrive LSB first. Each one enters at the top and moves
         // down, so after DATA_W bits the first bit is at bit 0.
         ST_RDATA: begin
            if (M_GRANT && S_DVALID) begin
               w_rx_sr_nxt = {S_DIN, r_rx_sr[DATA_W-1:1]};
               if (r_bit_cnt == DATA_LAST) begin
                  w_state_nxt   = ST_DONE;
                  w_bit_cnt_nxt = '0;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               end
            end
         end

         ST_DONE: w_state_nxt = ST_IDLE;

         default: w_state_nxt = ST_IDLE;
      endcase

      // Output values for the state being entered.
      w_req_ready_nxt = (w_state_nxt == ST_IDLE);
      w_m_rqst_nxt    = w_state_nxt inside {ST_SEL0, ST_SEL1, ST_WAIT_GRANT,
                                            ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA};
      if (w_state_nxt == ST_SEL0) begin
         w_m_slave_sel_nxt = w_slave_nxt[0];
      end else if (w_state_nxt == ST_SEL1) begin
         w_m_slave_sel_nxt = w_slave_nxt[1];
      end
      if (w_state_nxt == ST_DONE) begin
         w_rsp_valid_nxt = 1'b1;
         w_m_tx_done_nxt = 1'b1;
         w_rsp_rdata_nxt = w_write_nxt ? '0 : w_rx_sr_nxt;
      end
   end

   // State, datapath and output registers with synchronous active-high reset.
   always_ff @(posedge MASTER_CLK) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge regardless of statement order.
      if (MASTER_RST) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_write       <= 1'b0;
         r_slave       <= 2'd0;
         r_tx_sr       <= '0;
         r_wdata       <= '0;
         r_rx_sr       <= '0;
         r_req_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_m_rqst      <= 1'b0;
         r_m_slave_sel <= 1'b0;
         r_m_dout      <= 1'b0;
         r_m_dvalid    <= 1'b0;
         r_m_tx_done   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_write       <= w_write_nxt;
         r_slave       <= w_slave_nxt;
         r_tx_sr       <= w_tx_sr_nxt;
         r_wdata       <= w_wdata_nxt;
         r_rx_sr       <= w_rx_sr_nxt;
         r_req_ready   <= w_req_ready_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_m_rqst      <= w_m_rqst_nxt;
         r_m_slave_sel <= w_m_slave_sel_nxt;
         r_m_dout      <= w_m_dout_nxt;
         r_m_dvalid    <= w_m_dvalid_nxt;
         r_m_tx_done   <= w_m_tx_done_nxt;
      end
   end

endmodule
